// File: rtl/cache_axi_arbiter.sv
// Round-robin arbiter sharing one AXI-bridge request/data port between the
// instruction cache (s0) and the data cache (s1); grant is held for a whole burst.
module cache_axi_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  s0_rw_addr_valid,
    output logic                  s0_rw_addr_ready,
    input  logic [ADDR_WIDTH-1:0] s0_rw_addr,
    input  logic                  s0_rw_we,
    input  logic [7:0]            s0_rw_len,
    input  logic [2:0]            s0_rw_size,
    input  logic [1:0]            s0_rw_burst,
    input  logic                  s0_rw_if,
    input  logic                  s0_w_data_valid,
    output logic                  s0_w_data_ready,
    input  logic [DATA_WIDTH-1:0] s0_w_data,
    output logic                  s0_r_data_valid,
    input  logic                  s0_r_data_ready,
    output logic [DATA_WIDTH-1:0] s0_r_data,

    input  logic                  s1_rw_addr_valid,
    output logic                  s1_rw_addr_ready,
    input  logic [ADDR_WIDTH-1:0] s1_rw_addr,
    input  logic                  s1_rw_we,
    input  logic [7:0]            s1_rw_len,
    input  logic [2:0]            s1_rw_size,
    input  logic [1:0]            s1_rw_burst,
    input  logic                  s1_rw_if,
    input  logic                  s1_w_data_valid,
    output logic                  s1_w_data_ready,
    input  logic [DATA_WIDTH-1:0] s1_w_data,
    output logic                  s1_r_data_valid,
    input  logic                  s1_r_data_ready,
    output logic [DATA_WIDTH-1:0] s1_r_data,

    output logic                  m_rw_addr_valid,
    input  logic                  m_rw_addr_ready,
    output logic [ADDR_WIDTH-1:0] m_rw_addr,
    output logic                  m_rw_we,
    output logic [7:0]            m_rw_len,
    output logic [2:0]            m_rw_size,
    output logic [1:0]            m_rw_burst,
    output logic                  m_rw_if,
    output logic                  m_w_data_valid,
    input  logic                  m_w_data_ready,
    output logic [DATA_WIDTH-1:0] m_w_data,
    input  logic                  m_r_data_valid,
    output logic                  m_r_data_ready,
    input  logic [DATA_WIDTH-1:0] m_r_data,

    output logic [1:0]            grant
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ADDR  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;
    localparam logic [1:0] RDATA = 2'd3;

    logic [1:0] state;
    logic       fav_s1;
    logic [7:0] len_q;
    logic [7:0] cnt;
    logic [1:0] winner;
    logic       sel1;
    logic       active;
    logic       addr_hs;
    logic       w_beat;
    logic       r_beat;
    logic       last_beat;

    // fav_s1 remembers who lost last time: on a tie the other port wins.
    function automatic logic [1:0] pick(input logic v0, input logic v1, input logic fav1);
        if (v0 && v1)
            return fav1 ? 2'b10 : 2'b01;
        else if (v0)
            return 2'b01;
        else if (v1)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign winner    = pick(s0_rw_addr_valid, s1_rw_addr_valid, fav_s1);
    assign sel1      = grant[1];
    assign active    = ~rst;
    assign addr_hs   = m_rw_addr_valid & m_rw_addr_ready;
    assign w_beat    = m_w_data_valid & m_w_data_ready;
    assign r_beat    = m_r_data_valid & m_r_data_ready;
    assign last_beat = (cnt == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 2'b00;
            fav_s1 <= 1'b0;
            cnt    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (winner != 2'b00) begin
                        grant  <= winner;
                        fav_s1 <= winner[0];
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (addr_hs) begin
                        cnt   <= 8'd0;
                        state <= m_rw_we ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if ((state == WDATA) ? w_beat : r_beat) begin
                        if (last_beat) begin
                            state <= IDLE;
                            grant <= 2'b00;
                            cnt   <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Burst length is data, captured with the address handshake only.
    always_ff @(posedge clk) begin
        if (state == ADDR && addr_hs)
            len_q <= m_rw_len;
    end

    assign m_rw_addr_valid = active && (state == ADDR) && (sel1 ? s1_rw_addr_valid : s0_rw_addr_valid);
    assign m_rw_addr       = sel1 ? s1_rw_addr  : s0_rw_addr;
    assign m_rw_we         = sel1 ? s1_rw_we    : s0_rw_we;
    assign m_rw_len        = sel1 ? s1_rw_len   : s0_rw_len;
    assign m_rw_size       = sel1 ? s1_rw_size  : s0_rw_size;
    assign m_rw_burst      = sel1 ? s1_rw_burst : s0_rw_burst;
    assign m_rw_if         = sel1 ? s1_rw_if    : s0_rw_if;

    assign m_w_data_valid  = active && (state == WDATA) && (sel1 ? s1_w_data_valid : s0_w_data_valid);
    assign m_w_data        = sel1 ? s1_w_data : s0_w_data;
    assign m_r_data_ready  = active && (state == RDATA) && (sel1 ? s1_r_data_ready : s0_r_data_ready);

    assign s0_rw_addr_ready = active && (state == ADDR)  && grant[0] && m_rw_addr_ready;
    assign s1_rw_addr_ready = active && (state == ADDR)  && grant[1] && m_rw_addr_ready;
    assign s0_w_data_ready  = active && (state == WDATA) && grant[0] && m_w_data_ready;
    assign s1_w_data_ready  = active && (state == WDATA) && grant[1] && m_w_data_ready;
    assign s0_r_data_valid  = active && (state == RDATA) && grant[0] && m_r_data_valid;
    assign s1_r_data_valid  = active && (state == RDATA) && grant[1] && m_r_data_valid;
    assign s0_r_data        = grant[0] ? m_r_data : '0;
    assign s1_r_data        = grant[1] ? m_r_data : '0;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: arbitration order, burst pass-through,
// burst-length boundaries, mid-burst reset and address back-pressure.
module tb_cache_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        s0_rw_addr_valid = 0, s0_rw_addr_ready;
    logic [31:0] s0_rw_addr = 0;
    logic        s0_rw_we = 0;
    logic [7:0]  s0_rw_len = 0;
    logic [2:0]  s0_rw_size = 3'd3;
    logic [1:0]  s0_rw_burst = 2'd1;
    logic        s0_rw_if = 1'b1;
    logic        s0_w_data_valid = 0, s0_w_data_ready;
    logic [63:0] s0_w_data = 0;
    logic        s0_r_data_valid, s0_r_data_ready = 0;
    logic [63:0] s0_r_data;

    logic        s1_rw_addr_valid = 0, s1_rw_addr_ready;
    logic [31:0] s1_rw_addr = 0;
    logic        s1_rw_we = 0;
    logic [7:0]  s1_rw_len = 0;
    logic [2:0]  s1_rw_size = 3'd3;
    logic [1:0]  s1_rw_burst = 2'd1;
    logic        s1_rw_if = 1'b0;
    logic        s1_w_data_valid = 0, s1_w_data_ready;
    logic [63:0] s1_w_data = 0;
    logic        s1_r_data_valid, s1_r_data_ready = 0;
    logic [63:0] s1_r_data;

    logic        m_rw_addr_valid, m_rw_addr_ready = 0;
    logic [31:0] m_rw_addr;
    logic        m_rw_we;
    logic [7:0]  m_rw_len;
    logic [2:0]  m_rw_size;
    logic [1:0]  m_rw_burst;
    logic        m_rw_if;
    logic        m_w_data_valid, m_w_data_ready = 0;
    logic [63:0] m_w_data;
    logic        m_r_data_valid = 0, m_r_data_ready;
    logic [63:0] m_r_data = 0;
    logic [1:0]  grant;

    int n_cmp = 0;
    int n_err = 0;

    cache_axi_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .s0_rw_addr_valid(s0_rw_addr_valid), .s0_rw_addr_ready(s0_rw_addr_ready),
        .s0_rw_addr(s0_rw_addr), .s0_rw_we(s0_rw_we), .s0_rw_len(s0_rw_len),
        .s0_rw_size(s0_rw_size), .s0_rw_burst(s0_rw_burst), .s0_rw_if(s0_rw_if),
        .s0_w_data_valid(s0_w_data_valid), .s0_w_data_ready(s0_w_data_ready), .s0_w_data(s0_w_data),
        .s0_r_data_valid(s0_r_data_valid), .s0_r_data_ready(s0_r_data_ready), .s0_r_data(s0_r_data),
        .s1_rw_addr_valid(s1_rw_addr_valid), .s1_rw_addr_ready(s1_rw_addr_ready),
        .s1_rw_addr(s1_rw_addr), .s1_rw_we(s1_rw_we), .s1_rw_len(s1_rw_len),
        .s1_rw_size(s1_rw_size), .s1_rw_burst(s1_rw_burst), .s1_rw_if(s1_rw_if),
        .s1_w_data_valid(s1_w_data_valid), .s1_w_data_ready(s1_w_data_ready), .s1_w_data(s1_w_data),
        .s1_r_data_valid(s1_r_data_valid), .s1_r_data_ready(s1_r_data_ready), .s1_r_data(s1_r_data),
        .m_rw_addr_valid(m_rw_addr_valid), .m_rw_addr_ready(m_rw_addr_ready),
        .m_rw_addr(m_rw_addr), .m_rw_we(m_rw_we), .m_rw_len(m_rw_len),
        .m_rw_size(m_rw_size), .m_rw_burst(m_rw_burst), .m_rw_if(m_rw_if),
        .m_w_data_valid(m_w_data_valid), .m_w_data_ready(m_w_data_ready), .m_w_data(m_w_data),
        .m_r_data_valid(m_r_data_valid), .m_r_data_ready(m_r_data_ready), .m_r_data(m_r_data),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s0_rw_addr_valid = 0; s1_rw_addr_valid = 0;
        s0_w_data_valid = 0;  s1_w_data_valid = 0;
        s0_r_data_ready = 0;  s1_r_data_ready = 0;
        m_rw_addr_ready = 0;  m_w_data_ready = 0; m_r_data_valid = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int beats;
        int bad;

        // Reset state
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_m_av", m_rw_addr_valid, 0);
        chk("rst_m_wv", m_w_data_valid, 0);
        chk("rst_m_rr", m_r_data_ready, 0);
        chk("rst_s0_ar", s0_rw_addr_ready, 0);
        chk("rst_s1_rv", s1_r_data_valid, 0);
        rst = 1'b0;

        // Simultaneous requests after reset: s0 first, then s1 after one idle cycle
        s0_rw_addr = 32'h0000_1000; s0_rw_we = 0; s0_rw_len = 8'd7; s0_rw_addr_valid = 1;
        s1_rw_addr = 32'h0000_2000; s1_rw_we = 0; s1_rw_len = 8'd7; s1_rw_addr_valid = 1;
        #1;
        chk("idle_m_av", m_rw_addr_valid, 0);
        tick();
        chk("tie_grant_s0", grant, 2'b01);
        chk("tie_m_av", m_rw_addr_valid, 1);
        chk("tie_m_addr", m_rw_addr, 32'h0000_1000);
        m_rw_addr_ready = 1;
        #1;
        chk("s0_ar", s0_rw_addr_ready, 1);
        chk("s1_ar", s1_rw_addr_ready, 0);
        tick();
        s0_rw_addr_valid = 0; m_rw_addr_ready = 0;
        m_r_data_valid = 1; s0_r_data_ready = 1;
        for (int i = 0; i < 8; i++) begin
            m_r_data = 64'hB000 + 64'(i);
            #1;
            chk("rd_s0_data", s0_r_data, 64'hB000 + 64'(i));
            chk("rd_s0_valid", s0_r_data_valid, 1);
            chk("rd_s1_valid", s1_r_data_valid, 0);
            chk("rd_s1_data", s1_r_data, 0);
            tick();
        end
        m_r_data_valid = 0;
        #1;
        chk("gap_grant", grant, 2'b00);
        chk("gap_m_av", m_rw_addr_valid, 0);
        tick();
        chk("next_grant_s1", grant, 2'b10);
        chk("next_m_addr", m_rw_addr, 32'h0000_2000);

        // s1 write burst, len 7, toggling downstream ready
        do_reset();
        s1_rw_addr = 32'h8000_1000; s1_rw_we = 1; s1_rw_len = 8'd7; s1_rw_addr_valid = 1;
        tick();
        chk("wr_grant", grant, 2'b10);
        m_rw_addr_ready = 1;
        #1;
        chk("wr_m_addr", m_rw_addr, 32'h8000_1000);
        chk("wr_m_we", m_rw_we, 1);
        chk("wr_m_len", m_rw_len, 8'd7);
        chk("wr_m_if", m_rw_if, 0);
        tick();
        s1_rw_addr_valid = 0; m_rw_addr_ready = 0; s1_w_data_valid = 1;
        beats = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            m_w_data_ready = (c % 2 == 1);
            s1_w_data = 64'hA000 + 64'(beats);
            #1;
            chk("wr_s0_wr", s0_w_data_ready, 0);
            chk("wr_s0_ar", s0_rw_addr_ready, 0);
            chk("wr_s0_rv", s0_r_data_valid, 0);
            chk("wr_grant_hold", grant, 2'b10);
            if (m_w_data_ready) begin
                chk("wr_beat_data", m_w_data, 64'hA000 + 64'(beats));
                chk("wr_s1_wr", s1_w_data_ready, 1);
                beats++;
            end
            tick();
        end
        chk("wr_beats", beats, 8);
        m_w_data_ready = 0;
        #1;
        chk("wr_done_grant", grant, 2'b00);
        chk("wr_done_m_wv", m_w_data_valid, 0);
        s1_w_data_valid = 0;

        // Continuous requests from both: grants alternate, len 0 bursts end in one beat
        do_reset();
        s0_rw_we = 0; s0_rw_len = 0; s1_rw_we = 0; s1_rw_len = 0;
        s0_rw_addr_valid = 1; s1_rw_addr_valid = 1;
        m_rw_addr_ready = 1; m_r_data_valid = 1; s0_r_data_ready = 1; s1_r_data_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("rr_single_beat", m_r_data_ready, 1);
            tick();
            chk("rr_idle_after_len0", grant, 2'b00);
        end

        // Withdrawn request before the arbitration edge is not granted
        do_reset();
        s1_rw_addr_valid = 1;
        #2;
        s1_rw_addr_valid = 0;
        tick();
        chk("withdraw_grant", grant, 2'b00);

        // len 255: 256 beats, no early release
        do_reset();
        s0_rw_we = 0; s0_rw_len = 8'd255; s0_rw_addr_valid = 1;
        m_rw_addr_ready = 1;
        tick();
        tick();
        s0_rw_addr_valid = 0; m_rw_addr_ready = 0;
        m_r_data_valid = 1; s0_r_data_ready = 1;
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (grant != 2'b01) bad++;
        end
        chk("len255_no_early", bad, 0);
        chk("len255_last_valid", s0_r_data_valid, 1);
        tick();
        chk("len255_done", grant, 2'b00);
        chk("len255_done_rv", s0_r_data_valid, 0);

        // Reset in the middle of a write burst, then a fresh request
        do_reset();
        s1_rw_we = 1; s1_rw_len = 8'd7; s1_rw_addr_valid = 1; m_rw_addr_ready = 1;
        tick();
        tick();
        s1_rw_addr_valid = 0; m_rw_addr_ready = 0;
        s1_w_data_valid = 1; m_w_data_ready = 1;
        tick();
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("abort_grant", grant, 2'b00);
        chk("abort_m_wv", m_w_data_valid, 0);
        s1_w_data_valid = 0; m_w_data_ready = 0;
        s1_rw_we = 0; s1_rw_len = 0; s1_rw_addr_valid = 1;
        tick();
        chk("post_abort_grant", grant, 2'b10);
        chk("post_abort_m_av", m_rw_addr_valid, 1);

        // Address back-pressure: request held stable
        do_reset();
        s0_rw_addr = 32'h1234_5678; s0_rw_we = 0; s0_rw_len = 8'd3; s0_rw_addr_valid = 1;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_m_av", m_rw_addr_valid, 1);
            chk("bp_m_addr", m_rw_addr, 32'h1234_5678);
            chk("bp_m_len", m_rw_len, 8'd3);
            chk("bp_grant", grant, 2'b01);
            tick();
        end
        m_rw_addr_ready = 1;
        #1;
        chk("bp_release_ar", s0_rw_addr_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule
